// File: rtl/dsi_depacketizer.sv
// DSI receive depacketizer: parses short/long packets from a byte stream, streams payload, flags errors.
// Optional payload CRC-16 checking is enabled by defining DSI_RX_CRC_CHECK_EN.
module dsi_depacketizer #(
   parameter int MAX_WC = 48
) (
   input  logic        dsi_clk,
   input  logic        dsi_rst_n,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic [7:0]  pkt_di,
   output logic [15:0] pkt_wc,
   output logic [7:0]  pkt_ecc,
   output logic [15:0] pkt_crc,
   output logic        pkt_long,
   output logic        pkt_done,
   output logic [7:0]  pld_data,
   output logic        pld_valid,
   output logic        frame_err,
   output logic        crc_err
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_SYNC, ST_DI, ST_WC0, ST_WC1, ST_ECC,
      ST_PLD, ST_CRC0, ST_CRC1, ST_TFF, ST_TEND
   } state_t;

   localparam logic [15:0] MAX_WC_C = MAX_WC[15:0];

   state_t      state_r;
   state_t      state_nxt_s;
   logic        long_r;
   logic [7:0]  di_sh_r;
   logic [15:0] wc_sh_r;
   logic [7:0]  ecc_sh_r;
   logic [15:0] crc_sh_r;
   logic [15:0] cnt_r;
   logic        done_s;
   logic        ferr_s;
   logic        pld_v_s;
   logic        wc_big_s;
   logic [7:0]  start_code_s;

   assign wc_big_s     = ({rx_byte, wc_sh_r[7:0]} > MAX_WC_C);
   assign start_code_s = long_r ? 8'h81 : 8'h01;

   // FSM state register
   always_ff @(posedge dsi_clk or negedge dsi_rst_n) begin
      if (!dsi_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; every transition needs an accepted byte
   always_comb begin
      state_nxt_s = state_r;
      if (rx_valid) begin
         case (state_r)
            ST_IDLE: begin
               if ((rx_byte == 8'h01) || (rx_byte == 8'h81)) state_nxt_s = ST_SYNC;
               else                                          state_nxt_s = ST_IDLE;
            end
            ST_SYNC: begin
               if (rx_byte == 8'hFF) state_nxt_s = ST_DI;
               else                  state_nxt_s = ST_IDLE;
            end
            ST_DI:  state_nxt_s = ST_WC0;
            ST_WC0: state_nxt_s = ST_WC1;
            ST_WC1: begin
               if (long_r && wc_big_s) state_nxt_s = ST_IDLE;
               else                    state_nxt_s = ST_ECC;
            end
            ST_ECC: begin
               if (!long_r)                   state_nxt_s = ST_TFF;
               else if (wc_sh_r == 16'h0000)  state_nxt_s = ST_CRC0;
               else                           state_nxt_s = ST_PLD;
            end
            ST_PLD: begin
               if (cnt_r == 16'h0001) state_nxt_s = ST_CRC0;
               else                   state_nxt_s = ST_PLD;
            end
            ST_CRC0: state_nxt_s = ST_CRC1;
            ST_CRC1: state_nxt_s = ST_TFF;
            ST_TFF: begin
               if (rx_byte == 8'hFF) state_nxt_s = ST_TEND;
               else                  state_nxt_s = ST_IDLE;
            end
            ST_TEND: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // FSM output decode feeding the registered output stage
   always_comb begin
      done_s  = 1'b0;
      ferr_s  = 1'b0;
      pld_v_s = 1'b0;
      if (rx_valid) begin
         case (state_r)
            ST_SYNC: ferr_s  = (rx_byte != 8'hFF);
            ST_WC1:  ferr_s  = long_r && wc_big_s;
            ST_PLD:  pld_v_s = 1'b1;
            ST_TFF:  ferr_s  = (rx_byte != 8'hFF);
            ST_TEND: begin
               done_s = (rx_byte == start_code_s);
               ferr_s = (rx_byte != start_code_s);
            end
            default: begin
               done_s  = 1'b0;
               ferr_s  = 1'b0;
               pld_v_s = 1'b0;
            end
         endcase
      end else begin
         done_s  = 1'b0;
         ferr_s  = 1'b0;
         pld_v_s = 1'b0;
      end
   end

   // Header shadow registers and payload byte counter
   always_ff @(posedge dsi_clk or negedge dsi_rst_n) begin
      if (!dsi_rst_n) begin
         long_r   <= 1'b0;
         di_sh_r  <= 8'h00;
         wc_sh_r  <= 16'h0000;
         ecc_sh_r <= 8'h00;
         crc_sh_r <= 16'h0000;
         cnt_r    <= 16'h0000;
      end else if (rx_valid) begin
         case (state_r)
            ST_IDLE: begin
               if ((rx_byte == 8'h01) || (rx_byte == 8'h81)) begin
                  long_r   <= (rx_byte == 8'h81);
                  crc_sh_r <= 16'h0000;
               end
            end
            ST_DI:   di_sh_r        <= rx_byte;
            ST_WC0:  wc_sh_r[7:0]   <= rx_byte;
            ST_WC1:  wc_sh_r[15:8]  <= rx_byte;
            ST_ECC: begin
               ecc_sh_r <= rx_byte;
               cnt_r    <= wc_sh_r;
            end
            ST_PLD:  cnt_r          <= cnt_r - 16'h0001;
            ST_CRC0: crc_sh_r[7:0]  <= rx_byte;
            ST_CRC1: crc_sh_r[15:8] <= rx_byte;
            default: cnt_r          <= cnt_r;
         endcase
      end
   end

   // Registered outputs; pkt_* only change on a cleanly framed packet
   always_ff @(posedge dsi_clk or negedge dsi_rst_n) begin
      if (!dsi_rst_n) begin
         pkt_di    <= 8'h00;
         pkt_wc    <= 16'h0000;
         pkt_ecc   <= 8'h00;
         pkt_crc   <= 16'h0000;
         pkt_long  <= 1'b0;
         pkt_done  <= 1'b0;
         pld_data  <= 8'h00;
         pld_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         pkt_done  <= done_s;
         frame_err <= ferr_s;
         pld_valid <= pld_v_s;
         if (pld_v_s) pld_data <= rx_byte;
         if (done_s) begin
            pkt_di   <= di_sh_r;
            pkt_wc   <= wc_sh_r;
            pkt_ecc  <= ecc_sh_r;
            pkt_crc  <= crc_sh_r;
            pkt_long <= long_r;
         end
      end
   end

`ifdef DSI_RX_CRC_CHECK_EN
   logic [15:0] crc_acc_r;

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         if (c[0]) c = (c >> 1) ^ 16'h8408;
         else      c = c >> 1;
      end
      return c;
   endfunction

   // Payload CRC accumulator, re-seeded while the ECC byte goes by
   always_ff @(posedge dsi_clk or negedge dsi_rst_n) begin
      if (!dsi_rst_n) begin
         crc_acc_r <= 16'hFFFF;
      end else if (rx_valid && (state_r == ST_ECC)) begin
         crc_acc_r <= 16'hFFFF;
      end else if (rx_valid && (state_r == ST_PLD)) begin
         crc_acc_r <= crc16_byte(crc_acc_r, rx_byte);
      end
   end

   // CRC verdict is latched together with pkt_done
   always_ff @(posedge dsi_clk or negedge dsi_rst_n) begin
      if (!dsi_rst_n) begin
         crc_err <= 1'b0;
      end else if (done_s) begin
         crc_err <= long_r && (crc_acc_r != crc_sh_r);
      end
   end
`else
   assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_dsi_depacketizer.sv
// Self-checking bench for dsi_depacketizer: directed and randomized packets against a packet-level model.
module tb_dsi_depacketizer;

   localparam int MAX_WC = 48;
`ifdef DSI_RX_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   typedef logic [7:0] byte_t;

   logic        dsi_clk = 1'b0;
   logic        dsi_rst_n;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic [7:0]  pkt_di;
   logic [15:0] pkt_wc;
   logic [7:0]  pkt_ecc;
   logic [15:0] pkt_crc;
   logic        pkt_long;
   logic        pkt_done;
   logic [7:0]  pld_data;
   logic        pld_valid;
   logic        frame_err;
   logic        crc_err;

   dsi_depacketizer #(.MAX_WC(MAX_WC)) dut (
      .dsi_clk(dsi_clk), .dsi_rst_n(dsi_rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .pkt_di(pkt_di), .pkt_wc(pkt_wc), .pkt_ecc(pkt_ecc), .pkt_crc(pkt_crc),
      .pkt_long(pkt_long), .pkt_done(pkt_done), .pld_data(pld_data), .pld_valid(pld_valid),
      .frame_err(frame_err), .crc_err(crc_err)
   );

   always #5 dsi_clk = ~dsi_clk;

   int tests = 0;
   int fails = 0;

   // model of the pkt_* outputs as they should currently read
   logic [7:0]  m_di = 8'h00, m_ecc = 8'h00;
   logic [15:0] m_wc = 16'h0000, m_crc = 16'h0000;
   logic        m_long = 1'b0;
   // packet under test
   byte_t       q[$];
   byte_t       pl_q[$];
   int          err_at, done_at, pld_lo, pld_hi;
   logic [7:0]  n_di, n_ecc;
   logic [15:0] n_wc, n_crc;
   logic        n_long, n_crc_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] crc16(input byte_t d[$]);
      logic [15:0] c = 16'hFFFF;
      logic fb;
      foreach (d[k]) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ d[k][b];
            c  = c >> 1;
            if (fb) c = c ^ 16'h8408;
         end
      end
      return c;
   endfunction

   task automatic build_short(input byte_t di, input byte_t d0, input byte_t d1,
                              input byte_t ecc, input byte_t tend);
      q = {8'h01, 8'hFF, di, d0, d1, ecc, 8'hFF, tend};
      pld_lo = 0; pld_hi = 0;
      err_at  = (tend == 8'h01) ? -1 : 7;
      done_at = (tend == 8'h01) ? 7 : -1;
      n_di = di; n_wc = {d1, d0}; n_ecc = ecc; n_crc = 16'h0000;
      n_long = 1'b0; n_crc_err = 1'b0;
   endtask

   // payload is taken from pl_q
   task automatic build_long(input byte_t di, input logic [15:0] wc, input byte_t ecc,
                             input logic [15:0] crc, input byte_t tend);
      q = {8'h81, 8'hFF, di, wc[7:0], wc[15:8], ecc};
      pld_lo = 0; pld_hi = 0; done_at = -1;
      if (int'(wc) > MAX_WC) begin
         q = q[0:4];
         err_at = 4;
      end else begin
         pld_lo = 6; pld_hi = 6 + int'(wc);
         q = {q, pl_q, crc[7:0], crc[15:8], 8'hFF, tend};
         err_at  = (tend == 8'h81) ? -1 : q.size() - 1;
         done_at = (tend == 8'h81) ? q.size() - 1 : -1;
      end
      n_di = di; n_wc = wc; n_ecc = ecc; n_crc = crc; n_long = 1'b1;
      n_crc_err = CRC_EN && (crc16(pl_q) != crc);
   endtask

   task automatic fill_payload(input int n);
      pl_q = {};
      for (int k = 0; k < n; k++) pl_q.push_back(byte_t'($urandom_range(0, 255)));
   endtask

   // feed up to nmax bytes of q with `stall` idle cycles after each and check every response
   task automatic run(input int stall, input int nmax);
      for (int i = 0; i < q.size() && i < nmax; i++) begin
         rx_byte = q[i]; rx_valid = 1'b1;
         @(posedge dsi_clk); #1;
         rx_valid = 1'b0;
         chk("pld_valid", 64'(pld_valid), 64'(i >= pld_lo && i < pld_hi));
         if (i >= pld_lo && i < pld_hi) chk("pld_data", 64'(pld_data), 64'(q[i]));
         chk("frame_err", 64'(frame_err), 64'(i == err_at));
         chk("pkt_done", 64'(pkt_done), 64'(i == done_at));
         if (i == done_at) begin
            m_di = n_di; m_wc = n_wc; m_ecc = n_ecc; m_crc = n_crc; m_long = n_long;
            chk("crc_err", 64'(crc_err), 64'(n_crc_err));
         end
         if (i == err_at) break;
         for (int s = 0; s < stall; s++) begin
            @(posedge dsi_clk); #1;
            chk("stall_quiet", 64'({pld_valid, pkt_done, frame_err}), 64'(3'b000));
         end
      end
      chk("pkt_fields", {8'h00, pkt_di, pkt_wc, pkt_ecc, pkt_crc, 7'h00, pkt_long},
                        {8'h00, m_di, m_wc, m_ecc, m_crc, 7'h00, m_long});
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {3'b000, pkt_di, pkt_wc, pkt_ecc, pkt_crc, pkt_long, pkt_done, pld_data,
                pld_valid, frame_err, crc_err}, 64'h0);
   endtask

   initial begin
      dsi_rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
      repeat (3) @(posedge dsi_clk);
      #1;
      chk_all_zero("reset_outputs");
      dsi_rst_n = 1'b1;
      @(posedge dsi_clk); #1;

      // bytes that are not start codes are silently dropped in IDLE
      q = {};
      for (int k = 0; k < 6; k++) q.push_back(byte_t'($urandom_range(2, 128)));
      err_at = -1; done_at = -1; pld_lo = 0; pld_hi = 0;
      run(0, 100);

      build_short(8'h05, 8'hFE, 8'hCA, 8'h3C, 8'h01);
      run(0, 100);
      chk("short_wc", 64'(pkt_wc), 64'(16'hCAFE));

      pl_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      build_long(8'h29, 16'd9, 8'h11, 16'h6F91, 8'h81);
      run(0, 100);
      chk("long_crc_ref", 64'(crc16(pl_q)), 64'(16'h6F91));

      build_long(8'h29, 16'd9, 8'h11, 16'h1234, 8'h81);
      run(0, 100);

      pl_q = {};
      build_long(8'h2A, 16'd0, 8'h22, 16'hFFFF, 8'h81);
      run(3, 100);

      q = {8'h01, 8'h00}; err_at = 1; done_at = -1; pld_lo = 0; pld_hi = 0;
      run(0, 100);
      build_short(8'h15, 8'h34, 8'h12, 8'h07, 8'h01);
      run(0, 100);

      fill_payload(0);
      build_long(8'h39, 16'd49, 8'h00, 16'h0000, 8'h81);
      run(0, 100);

      fill_payload(MAX_WC);
      build_long(8'h3A, 16'(MAX_WC), 8'h5A, crc16(pl_q), 8'h81);
      run(0, 100);

      build_short(8'h06, 8'h11, 8'h22, 8'h33, 8'h02);
      run(0, 100);

      // randomized back-to-back traffic
      for (int p = 0; p < 20; p++) begin
         if ($urandom_range(0, 1) == 1) begin
            fill_payload($urandom_range(0, MAX_WC));
            build_long(byte_t'($urandom_range(0, 255)), 16'(pl_q.size()), byte_t'($urandom_range(0, 255)),
                       ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535)) : crc16(pl_q), 8'h81);
         end else begin
            build_short(byte_t'($urandom_range(0, 255)), byte_t'($urandom_range(0, 255)),
                        byte_t'($urandom_range(0, 255)), byte_t'($urandom_range(0, 255)), 8'h01);
         end
         run($urandom_range(0, 2), 100);
      end

      // reset during the 4th payload byte of a 9-byte packet
      fill_payload(9);
      build_long(8'h29, 16'd9, 8'h11, crc16(pl_q), 8'h81);
      run(0, 9);
      rx_byte = q[9]; rx_valid = 1'b1;
      #2 dsi_rst_n = 1'b0;
      #1 chk_all_zero("reset_async");
      @(posedge dsi_clk); #1;
      chk_all_zero("reset_held");
      rx_valid = 1'b0;
      dsi_rst_n = 1'b1;
      m_di = 8'h00; m_wc = 16'h0000; m_ecc = 8'h00; m_crc = 16'h0000; m_long = 1'b0;
      @(posedge dsi_clk); #1;
      build_short(8'h05, 8'hFE, 8'hCA, 8'h3C, 8'h01);
      run(0, 100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
